// File: rtl/histogram_readout.sv
// Drains a finished histogram from scratch memory into output memory, one 128-bit word every three
// cycles. Words never written are forced to zero, and all bins are summed into a pixel total.
module histogram_readout #(
  parameter int unsigned NUM_WORDS     = 64,
  parameter logic [15:0] OUT_BASE_ADDR = 16'h0,
  parameter bit          CLEAR_SCRATCH = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_WORDS-1:0] nz_mask,
  output logic [15:0]          scratch_memory_address_pointer0,
  input  logic [127:0]         scratch_memory_rdata0,
  output logic                 scratch_write_enable,
  output logic [15:0]          scratch_write_address,
  output logic [127:0]         scratch_memory_wdata,
  output logic                 output_memory_write_enable,
  output logic [15:0]          output_memory_address,
  output logic [127:0]         output_memory_wdata,
  output logic [31:0]          total_pixel_count,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {StIdle, StRd, StLat, StWr, StFin} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_WORDS-1:0] mask_q, mask_d;
  logic [31:0]          acc_q, acc_d;
  logic                 pend_q, pend_d;
  logic                 owe_q, owe_d;
  logic [15:0]          oaddr_q, oaddr_d;
  logic [127:0]         odata_q, odata_d;
  logic                 swe_q, swe_d;
  logic [15:0]          swaddr_q, swaddr_d;

  logic [127:0] word;
  logic [31:0]  word_sum;

  // Unwritten words may read back as X; the mask bit gates them out entirely.
  assign word     = mask_q[idx_q] ? scratch_memory_rdata0 : 128'b0;
  assign word_sum = word[127:96] + word[95:64] + word[63:32] + word[31:0];

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mask_d   = mask_q;
    acc_d    = acc_q;
    pend_d   = pend_q;
    owe_d    = 1'b0;
    oaddr_d  = oaddr_q;
    odata_d  = odata_q;
    swe_d    = 1'b0;
    swaddr_d = swaddr_q;
    unique case (state_q)
      StIdle: begin
        if (start || pend_q) begin
          if (start) mask_d = nz_mask;
          idx_d   = '0;
          acc_d   = '0;
          pend_d  = 1'b0;
          state_d = StRd;
        end
      end
      StRd:  state_d = StLat;
      StLat: state_d = StWr;
      StWr: begin
        owe_d   = 1'b1;
        oaddr_d = OUT_BASE_ADDR + 16'(idx_q);
        odata_d = word;
        if (CLEAR_SCRATCH) begin
          swe_d    = 1'b1;
          swaddr_d = 16'(idx_q);
        end
        acc_d   = acc_q + word_sum;
        idx_d   = idx_q + 1'b1;
        state_d = (idx_q == LAST_IDX) ? StFin : StRd;
      end
      StFin: begin
        state_d = StIdle;
        // A start coinciding with done is remembered and launched from idle.
        if (start) begin
          mask_d = nz_mask;
          pend_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      mask_q   <= '0;
      acc_q    <= '0;
      pend_q   <= 1'b0;
      owe_q    <= 1'b0;
      oaddr_q  <= '0;
      odata_q  <= '0;
      swe_q    <= 1'b0;
      swaddr_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mask_q   <= mask_d;
      acc_q    <= acc_d;
      pend_q   <= pend_d;
      owe_q    <= owe_d;
      oaddr_q  <= oaddr_d;
      odata_q  <= odata_d;
      swe_q    <= swe_d;
      swaddr_q <= swaddr_d;
    end
  end

  assign scratch_memory_address_pointer0 =
      (state_q == StRd || state_q == StLat) ? 16'(idx_q) : 16'h0;
  assign scratch_write_enable       = swe_q;
  assign scratch_write_address      = swaddr_q;
  assign scratch_memory_wdata       = 128'b0;
  assign output_memory_write_enable = owe_q;
  assign output_memory_address      = oaddr_q;
  assign output_memory_wdata        = odata_q;
  assign total_pixel_count          = acc_q;
  assign busy = (state_q == StRd) || (state_q == StLat) || (state_q == StWr);
  assign done = (state_q == StFin);

endmodule

// File: tb/tb_histogram_readout.sv
// Bench for histogram_readout: a scratch memory model with one-cycle read latency feeds the DUT,
// and a scoreboard of expected output writes is consumed as the DUT writes.
module tb_histogram_readout;

  localparam int NW = 64;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [63:0]  nz_mask;
  logic [15:0]  scratch_memory_address_pointer0;
  logic [127:0] scratch_memory_rdata0;
  logic         scratch_write_enable;
  logic [15:0]  scratch_write_address;
  logic [127:0] scratch_memory_wdata;
  logic         output_memory_write_enable;
  logic [15:0]  output_memory_address;
  logic [127:0] output_memory_wdata;
  logic [31:0]  total_pixel_count;
  logic         busy;
  logic         done;

  histogram_readout #(
    .NUM_WORDS    (NW),
    .OUT_BASE_ADDR(16'h0),
    .CLEAR_SCRATCH(1'b1)
  ) dut (
    .clock                          (clock),
    .reset                          (reset),
    .start                          (start),
    .nz_mask                        (nz_mask),
    .scratch_memory_address_pointer0(scratch_memory_address_pointer0),
    .scratch_memory_rdata0          (scratch_memory_rdata0),
    .scratch_write_enable           (scratch_write_enable),
    .scratch_write_address          (scratch_write_address),
    .scratch_memory_wdata           (scratch_memory_wdata),
    .output_memory_write_enable     (output_memory_write_enable),
    .output_memory_address          (output_memory_address),
    .output_memory_wdata            (output_memory_wdata),
    .total_pixel_count              (total_pixel_count),
    .busy                           (busy),
    .done                           (done)
  );

  always #5 clock = ~clock;

  // Scratch memory model: unwritten words read back as X.
  logic [127:0] mem [NW];
  bit           mem_valid [NW];

  always @(posedge clock) begin
    if (scratch_memory_address_pointer0 < 16'(NW) &&
        mem_valid[scratch_memory_address_pointer0[5:0]])
      scratch_memory_rdata0 <= mem[scratch_memory_address_pointer0[5:0]];
    else
      scratch_memory_rdata0 <= 'x;
  end

  typedef struct packed {
    logic [15:0]  addr;
    logic [127:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   owr_count = 0;
  int   swr_count = 0;
  int   done_count = 0;

  always @(negedge clock) begin
    if (reset !== 1'b1) begin
      exp_t e;
      if (done === 1'b1) done_count++;
      if (scratch_write_enable === 1'b1) swr_count++;
      if (output_memory_write_enable === 1'b1) begin
        owr_count++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr %h data %h, required no write",
                   output_memory_address, output_memory_wdata);
        end else begin
          e = sb_q.pop_front();
          if (output_memory_address !== e.addr || output_memory_wdata !== e.data) begin
            errors++;
            $display("FAIL output_write: got addr %h data %h, required addr %h data %h",
                     output_memory_address, output_memory_wdata, e.addr, e.data);
          end
          checks++;
          if (scratch_write_enable !== 1'b1 || scratch_write_address !== e.addr ||
              scratch_memory_wdata !== 128'b0) begin
            errors++;
            $display("FAIL scratch_clear: got we %b addr %h data %h, required we 1 addr %h data 0",
                     scratch_write_enable, scratch_write_address, scratch_memory_wdata, e.addr);
          end
        end
      end else if (scratch_write_enable !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL scratch_strobe_alone: got we %b, required 0", scratch_write_enable);
      end
    end
  end

  task automatic do_reset();
    reset   = 1'b1;
    start   = 1'b0;
    nz_mask = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic fill_index();
    for (int k = 0; k < NW; k++) begin
      mem[k]       = {4{32'(k)}};
      mem_valid[k] = 1'b1;
    end
  endtask

  task automatic push_expected(input logic [63:0] m, output logic [31:0] tot);
    logic [127:0] d;
    tot = '0;
    for (int k = 0; k < NW; k++) begin
      d = m[k] ? mem[k] : 128'b0;
      sb_q.push_back('{addr: 16'(k), data: d});
      tot = tot + d[127:96] + d[95:64] + d[63:32] + d[31:0];
    end
  endtask

  task automatic pulse_start(input logic [63:0] m);
    @(posedge clock);
    #1 start = 1'b1;
    nz_mask = m;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit timed_out);
    cycles    = 0;
    timed_out = 1'b1;
    while (cycles < budget) begin
      @(negedge clock);
      if (done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      cycles++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got busy %b done %b, required 0 0", busy, done);
    end
    checks++;
    if (output_memory_write_enable !== 1'b0 || scratch_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: got owe %b swe %b, required 0 0",
               output_memory_write_enable, scratch_write_enable);
    end
    checks++;
    if (output_memory_address !== 16'h0 || output_memory_wdata !== 128'b0 ||
        scratch_write_address !== 16'h0 || scratch_memory_address_pointer0 !== 16'h0) begin
      errors++;
      $display("FAIL reset_buses: got oaddr %h odata %h swaddr %h raddr %h, required all 0",
               output_memory_address, output_memory_wdata, scratch_write_address,
               scratch_memory_address_pointer0);
    end
    checks++;
    if (total_pixel_count !== 32'h0) begin
      errors++;
      $display("FAIL reset_total: got %h, required 0", total_pixel_count);
    end
  endtask

  task automatic test_full_drain();
    logic [31:0] tot;
    int cyc, ow0, sw0;
    bit to;
    fill_index();
    ow0 = owr_count;
    sw0 = swr_count;
    push_expected({64{1'b1}}, tot);
    pulse_start({64{1'b1}});
    wait_done(400, cyc, to);
    checks++;
    if (to || cyc != 3 * NW) begin
      errors++;
      $display("FAIL full_latency: got %0d cycles (timeout %b), required %0d", cyc, to, 3 * NW);
    end
    checks++;
    if (total_pixel_count !== 32'd8064) begin
      errors++;
      $display("FAIL full_total: got %0d, required 8064", total_pixel_count);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL full_busy_at_done: got %b, required 0", busy);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || total_pixel_count !== 32'd8064) begin
      errors++;
      $display("FAIL full_after_done: got done %b total %0d, required 0 8064",
               done, total_pixel_count);
    end
    checks++;
    if (sb_q.size() != 0 || owr_count - ow0 != 64 || swr_count - sw0 != 64) begin
      errors++;
      $display("FAIL full_write_count: got out %0d scratch %0d left %0d, required 64 64 0",
               owr_count - ow0, swr_count - sw0, sb_q.size());
    end
  endtask

  task automatic test_sparse_mask();
    logic [31:0] tot;
    int cyc;
    bit to;
    for (int k = 0; k < NW; k++) mem_valid[k] = 1'b0;
    mem[0]       = 128'h00000001_00000002_00000003_00000004;
    mem_valid[0] = 1'b1;
    push_expected(64'h1, tot);
    pulse_start(64'h1);
    wait_done(400, cyc, to);
    checks++;
    if (to || total_pixel_count !== 32'd10) begin
      errors++;
      $display("FAIL sparse_total: got %0d (timeout %b), required 10", total_pixel_count, to);
    end
    @(negedge clock);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sparse_writes: got %0d missing, required 0", sb_q.size());
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [31:0] tot;
    int cyc, ow0, dn0;
    bit to;
    fill_index();
    ow0 = owr_count;
    dn0 = done_count;
    push_expected({64{1'b1}}, tot);
    pulse_start({64{1'b1}});
    repeat (32) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || output_memory_write_enable !== 1'b0 ||
        total_pixel_count !== 32'h0) begin
      errors++;
      $display("FAIL abort_outputs: got busy %b done %b owe %b total %h, required 0 0 0 0",
               busy, done, output_memory_write_enable, total_pixel_count);
    end
    repeat (4) @(negedge clock);
    sb_q.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (10) @(negedge clock);
    checks++;
    if (owr_count - ow0 != 10 || done_count != dn0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_writes: got %0d writes %0d dones busy %b, required 10 0 0",
               owr_count - ow0, done_count - dn0, busy);
    end
    push_expected({64{1'b1}}, tot);
    pulse_start({64{1'b1}});
    wait_done(400, cyc, to);
    checks++;
    if (to || cyc != 3 * NW || total_pixel_count !== 32'd8064) begin
      errors++;
      $display("FAIL restart_drain: got %0d cycles total %0d, required %0d 8064",
               cyc, total_pixel_count, 3 * NW);
    end
    @(negedge clock);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL restart_writes: got %0d missing, required 0", sb_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] tot_a, tot_b;
    logic [63:0] ma, mb;
    int cyc, ow0;
    bit to;
    fill_index();
    ma  = {32{2'b10}};
    mb  = 64'hFFFF_0000_0F0F_1234;
    ow0 = owr_count;
    push_expected(ma, tot_a);
    pulse_start(ma);
    repeat (20) @(posedge clock);
    #1 start = 1'b1;
    nz_mask = ~ma;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done(400, cyc, to);
    checks++;
    if (to || total_pixel_count !== 32'd4096) begin
      errors++;
      $display("FAIL busy_start_total: got %0d (timeout %b), required 4096", total_pixel_count, to);
    end
    // Start pulsed in the done cycle must launch a second full drain.
    push_expected(mb, tot_b);
    start   = 1'b1;
    nz_mask = mb;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done(400, cyc, to);
    checks++;
    if (to || total_pixel_count !== tot_b) begin
      errors++;
      $display("FAIL done_start_total: got %h (timeout %b), required %h",
               total_pixel_count, to, tot_b);
    end
    @(negedge clock);
    checks++;
    if (sb_q.size() != 0 || owr_count - ow0 != 128) begin
      errors++;
      $display("FAIL back_to_back_writes: got %0d writes %0d left, required 128 0",
               owr_count - ow0, sb_q.size());
    end
  endtask

  task automatic test_wrap();
    logic [31:0] tot;
    int cyc;
    bit to;
    for (int k = 0; k < NW; k++) begin
      mem[k]       = {128{1'b1}};
      mem_valid[k] = 1'b1;
    end
    push_expected({64{1'b1}}, tot);
    pulse_start({64{1'b1}});
    wait_done(400, cyc, to);
    checks++;
    if (to || total_pixel_count !== 32'hFFFF_FF00) begin
      errors++;
      $display("FAIL wrap_total: got %h (timeout %b), required ffffff00", total_pixel_count, to);
    end
    @(negedge clock);
  endtask

  task automatic test_random();
    logic [31:0] tot;
    logic [63:0] m;
    int cyc;
    bit to;
    for (int k = 0; k < NW; k++) begin
      mem[k]       = {$urandom(), $urandom(), $urandom(), $urandom()};
      mem_valid[k] = 1'b1;
    end
    m = {$urandom(), $urandom()};
    for (int k = 0; k < NW; k++) if (!m[k]) mem_valid[k] = 1'b0;
    push_expected(m, tot);
    pulse_start(m);
    wait_done(400, cyc, to);
    checks++;
    if (to || total_pixel_count !== tot) begin
      errors++;
      $display("FAIL random_total: got %h (timeout %b), required %h", total_pixel_count, to, tot);
    end
    @(negedge clock);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL random_writes: got %0d missing, required 0", sb_q.size());
    end
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    nz_mask = '0;
    test_reset();
    test_full_drain();
    test_sparse_mask();
    test_reset_mid_drain();
    test_back_to_back();
    test_wrap();
    test_random();
    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
